lsu: RTL and testbench

Load/store unit between the core's execute stage and data memory. It accepts one RV32I load or store per handshake and converts the byte address and funct3 into a word-addressed, byte-enabled memory transaction. It waits on a request/grant/response memory protocol, then returns sign- or zero-extended load data or a store acknowledge. It replaces the direct single-cycle word access to data memory, so memories with wait states can be used.

---
 rtl/lsu_if.sv | 47 ++++
 rtl/lsu.sv | 194 +++++++++++++++++++
 tb/tb_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Bus interfaces of the load/store unit.
//   lsu_req_if : core <-> LSU request/response handshake (master = core, slave = LSU)
//   lsu_mem_if : LSU <-> data memory request/grant/response (master = LSU, slave = memory)
interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one RV32I load/store into a word-addressed, byte-enabled
// memory transaction over a req/gnt/rvalid protocol and returns extended load data
// or a store acknowledge. Illegal or misaligned requests are answered with an error
// without touching memory.
// Optional feature: define LSU_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
module lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  core,
    lsu_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              is_legal;
    logic              is_misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    // Decode the incoming request: legality, alignment, lane enables and replicated store data
    always_comb begin
        is_legal      = 1'b0;
        is_misaligned = 1'b0;
        be_new        = 4'b1111;
        wdata_new     = core.req_wdata;
        case (core.req_funct3)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = !core.req_we;
            default:                is_legal = 1'b0;
        endcase
        case (core.req_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << core.req_addr[1:0];
                wdata_new = {4{core.req_wdata[7:0]}};
            end
            2'b01: begin
                be_new        = core.req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new     = {2{core.req_wdata[15:0]}};
                is_misaligned = core.req_addr[0];
            end
            default: begin
                is_misaligned = (core.req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Align the returned word to the addressed lane and sign/zero extend
    always_comb begin
        shifted = mem.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Next-state and registered-output logic of the transaction FSM
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (core.req_valid) begin
                    we_d     = core.req_we;
                    funct3_d = core.req_funct3;
                    off_d    = core.req_addr[1:0];
                    if (is_legal && !is_misaligned) begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = core.req_we;
                        mem_be_d    = be_new;
                        mem_addr_d  = core.req_addr[ADDR_W-1:2];
                        mem_wdata_d = wdata_new;
                    end else begin
                        // Rejected before any memory access
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end
                end
            end
            REQ: begin
                mem_req_d = 1'b1;
                if (mem.mem_gnt) begin
                    state_d   = WAIT;
                    mem_req_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_d      = RESP;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = we_q ? 32'd0 : load_data;
                end
`ifdef LSU_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            off_q        <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'd0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign core.req_ready  = (state_q == IDLE);
    assign core.resp_valid = (state_q == RESP);
    assign core.resp_rdata = resp_rdata_q;
    assign core.resp_err   = resp_err_q;
    assign mem.mem_req     = mem_req_q;
    assign mem.mem_we      = mem_we_q;
    assign mem.mem_be      = mem_be_q;
    assign mem.mem_addr    = mem_addr_q;
    assign mem.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed loads/stores against a byte-lane model,
// a scripted memory responder, and one compare process on the falling edge.
module tb_lsu;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if #(.ADDR_W(32)) core_if ();
    lsu_mem_if #(.ADDR_W(32)) mem_if ();

    lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_if.slave),
        .mem   (mem_if.master)
    );

    typedef struct {
        logic        we;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [29:0] addr;
        int          issue;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // memory responder configuration
    int          g_delay = 0;
    int          r_delay = 0;
    logic [31:0] m_rdata = 32'd0;
    int          gcnt = 0;
    int          rcnt = 0;
    bit          pending = 1'b0;

    // values captured by the compare process for the literal checks
    logic        saw_mem_req;
    logic [3:0]  last_be;
    logic [29:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_we;
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Byte-lane view of an RV32I access
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int gd, input int rdl);
        exp_t        e;
        int          nbytes;
        int          lane;
        logic        legal;
        logic [31:0] val;
        logic [31:0] mask;
        lane   = int'(addr % 4);
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        e.we    = we;
        e.addr  = addr[31:2];
        e.issue = 0;
        e.err   = !legal || ((lane % nbytes) != 0);
        e.be    = 4'(((1 << nbytes) - 1) << lane);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        val  = rd >> (8 * lane);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val  = val & mask;
        if (!f3[2] && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
        if (e.err) begin
            e.lat = 1;
        end else begin
            e.lat = 3 + gd + rdl;
`ifdef LSU_TIMEOUT_EN
            if (rdl + 1 > TO) begin
                e.err = 1'b1;
                e.lat = 2 + gd + TO;
            end
`endif
        end
        e.rdata = (we || e.err) ? 32'd0 : val;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Scripted memory: grant after g_delay REQ cycles, rvalid after r_delay further cycles
    always @(negedge clk) begin
        mem_if.mem_gnt    = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        mem_if.mem_rdata  = m_rdata;
        if (mem_if.mem_req) begin
            if (gcnt == g_delay) begin
                mem_if.mem_gnt = 1'b1;
                gcnt    = 0;
                pending = 1'b1;
                rcnt    = 0;
            end else begin
                gcnt++;
            end
        end else if (pending) begin
            if (rcnt == r_delay) begin
                mem_if.mem_rvalid = 1'b1;
                pending = 1'b0;
            end else begin
                rcnt++;
            end
        end
    end

    // Compare process: memory side while requesting, core side on every response
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() == 0) chk("req_ready_idle", core_if.req_ready, 1);
            if (mem_if.mem_req) begin
                saw_mem_req = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("mem_req_unexpected", mem_if.mem_req, 0);
                end else if (exp_q[0].err && exp_q[0].lat == 1) begin
                    chk("mem_req_on_err", mem_if.mem_req, 0);
                end else begin
                    chk("mem_we", mem_if.mem_we, exp_q[0].we);
                    chk("mem_be", mem_if.mem_be, exp_q[0].be);
                    chk("mem_addr", mem_if.mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) chk("mem_wdata", mem_if.mem_wdata, exp_q[0].wdata);
                    last_be    = mem_if.mem_be;
                    last_addr  = mem_if.mem_addr;
                    last_wdata = mem_if.mem_wdata;
                    last_we    = mem_if.mem_we;
                end
            end
            if (core_if.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", core_if.resp_valid, 0);
                end else begin
                    chk("resp_rdata", core_if.resp_rdata, exp_q[0].rdata);
                    chk("resp_err", core_if.resp_err, exp_q[0].err);
                    chk("resp_latency", cyc - exp_q[0].issue, exp_q[0].lat);
                    last_rdata = core_if.resp_rdata;
                    last_err   = core_if.resp_err;
                    last_lat   = cyc - exp_q[0].issue;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdl);
        exp_t e;
        @(negedge clk);
        g_delay = gd;
        r_delay = rdl;
        m_rdata = rd;
        gcnt    = 0;
        saw_mem_req = 1'b0;
        last_be = 'x; last_addr = 'x; last_wdata = 'x; last_we = 'x;
        last_rdata = 'x; last_err = 'x; last_lat = -1;
        e = model(we, f3, addr, wd, rd, gd, rdl);
        e.issue = cyc;
        exp_q.push_back(e);
        core_if.req_valid  = 1'b1;
        core_if.req_we     = we;
        core_if.req_funct3 = f3;
        core_if.req_addr   = addr;
        core_if.req_wdata  = wd;
        @(posedge clk);
        #1 core_if.req_valid = 1'b0;
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rdl);
        int n;
        issue(we, f3, addr, wd, rd, gd, rdl);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("resp_wait_bound", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        core_if.req_valid  = 1'b0;
        core_if.req_we     = 1'b0;
        core_if.req_funct3 = 3'd0;
        core_if.req_addr   = 32'd0;
        core_if.req_wdata  = 32'd0;
        mem_if.mem_gnt     = 1'b0;
        mem_if.mem_rvalid  = 1'b0;
        mem_if.mem_rdata   = 32'd0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", core_if.req_ready, 1);
        chk("rst_resp_valid", core_if.resp_valid, 0);
        chk("rst_resp_err", core_if.resp_err, 0);
        chk("rst_resp_rdata", core_if.resp_rdata, 0);
        chk("rst_mem_req", mem_if.mem_req, 0);
        chk("rst_mem_we", mem_if.mem_we, 0);
        chk("rst_mem_be", mem_if.mem_be, 0);
        chk("rst_mem_addr", mem_if.mem_addr, 0);
        chk("rst_mem_wdata", mem_if.mem_wdata, 0);
        reset = 1'b1;

        // LB 0x103
        run(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80AB_CDEF, 0, 0);
        $display("LB  0x103 rdata=%h err=%0d lat=%0d", last_rdata, last_err, last_lat);
        chk("lb_be", last_be, 4'b1000);
        chk("lb_addr", last_addr, 32'h40);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_lat", last_lat, 3);

        // LHU 0x102, grant stalled two cycles
        run(1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h80AB_CDEF, 2, 0);
        $display("LHU 0x102 rdata=%h err=%0d lat=%0d", last_rdata, last_err, last_lat);
        chk("lhu_rdata", last_rdata, 32'h0000_80AB);
        chk("lhu_lat", last_lat, 5);

        // SB 0x101
        run(1'b1, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
        $display("SB  0x101 wdata=%h be=%b lat=%0d", last_wdata, last_be, last_lat);
        chk("sb_we", last_we, 1);
        chk("sb_be", last_be, 4'b0010);
        chk("sb_wdata", last_wdata, 32'h7878_7878);
        chk("sb_rdata", last_rdata, 0);

        // error paths
        run(1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 0, 0);
        $display("LW  0x102 err=%0d lat=%0d", last_err, last_lat);
        chk("lw_mis_err", last_err, 1);
        chk("lw_mis_lat", last_lat, 1);
        chk("lw_mis_memreq", saw_mem_req, 0);
        run(1'b1, 3'b001, 32'h0000_0001, 32'hAAAA_5555, 32'd0, 0, 0);
        $display("SH  0x001 err=%0d lat=%0d", last_err, last_lat);
        chk("sh_mis_err", last_err, 1);
        chk("sh_mis_memreq", saw_mem_req, 0);
        run(1'b0, 3'b011, 32'h0000_0200, 32'd0, 32'd0, 0, 0);
        $display("L011 0x200 err=%0d lat=%0d", last_err, last_lat);
        chk("ld011_err", last_err, 1);
        run(1'b1, 3'b100, 32'h0000_0200, 32'd0, 32'd0, 0, 0);
        $display("S100 0x200 err=%0d lat=%0d", last_err, last_lat);
        chk("st100_err", last_err, 1);

        // more legal accesses, back to back
        run(1'b0, 3'b001, 32'h0000_0002, 32'd0, 32'h8001_1234, 0, 0);
        $display("LH  0x002 rdata=%h lat=%0d", last_rdata, last_lat);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        chk("lh_be", last_be, 4'b1100);
        run(1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 32'd0, 0, 1);
        $display("SW  0x200 wdata=%h lat=%0d", last_wdata, last_lat);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_lat", last_lat, 4);
        run(1'b0, 3'b100, 32'h0000_0002, 32'd0, 32'h00C3_0000, 1, 1);
        $display("LBU 0x002 rdata=%h lat=%0d", last_rdata, last_lat);
        chk("lbu_rdata", last_rdata, 32'h0000_00C3);
        run(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'd0, 0, 0);
        $display("SH  0x102 wdata=%h be=%b", last_wdata, last_be);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        run(1'b0, 3'b010, 32'h0000_0104, 32'd0, 32'h1357_9BDF, 0, 0);
        $display("LW  0x104 rdata=%h addr=%h", last_rdata, last_addr);
        chk("lw_addr", last_addr, 32'h41);
        chk("lw_rdata", last_rdata, 32'h1357_9BDF);

        // reset while waiting for rvalid; stale rvalid afterwards
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0, 32'h5555_AAAA, 0, 6);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_mem_req", mem_if.mem_req, 0);
        chk("midrst_req_ready", core_if.req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        $display("RST in WAIT mem_req=%0d req_ready=%0d", mem_if.mem_req, core_if.req_ready);
        chk("postrst_req_ready", core_if.req_ready, 1);
        chk("postrst_mem_req", mem_if.mem_req, 0);

        // long rvalid delay: timeout when enabled, normal completion otherwise
        run(1'b0, 3'b010, 32'h0000_0080, 32'd0, 32'hCAFE_F00D, 0, 20);
        $display("LW  0x080 long wait rdata=%h err=%0d lat=%0d", last_rdata, last_err, last_lat);
`ifdef LSU_TIMEOUT_EN
        chk("to_err", last_err, 1);
        chk("to_rdata", last_rdata, 0);
        chk("to_lat", last_lat, 6);
`else
        chk("longwait_err", last_err, 0);
        chk("longwait_rdata", last_rdata, 32'hCAFE_F00D);
        chk("longwait_lat", last_lat, 23);
`endif
        repeat (25) @(negedge clk);
        chk("final_req_ready", core_if.req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
